// File: rtl/wishbone_slice_timeout.sv
// rtl/wishbone_slice_timeout.sv - registered Wishbone request slice (IDLE/REQ/ACK) between AXI4-Lite bridge and SPU port
// Optional access watchdog is built when WISHBONE_SLICE_TIMEOUT_EN is defined.
module wishbone_slice_timeout #(
  parameter int          WB_ADR_BITS    = 13,
  parameter int          WB_DAT_BITS    = 64,
  parameter int          WB_SEL_BITS    = WB_DAT_BITS / 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                   s_wb_clk_i,
  input  logic                   s_wb_rst_i,
  input  logic [WB_ADR_BITS-1:0] s_wb_adr_i,
  input  logic [WB_DAT_BITS-1:0] s_wb_dat_i,
  output logic [WB_DAT_BITS-1:0] s_wb_dat_o,
  input  logic                   s_wb_we_i,
  input  logic [WB_SEL_BITS-1:0] s_wb_sel_i,
  input  logic                   s_wb_stb_i,
  output logic                   s_wb_ack_o,
  output logic [WB_ADR_BITS-1:0] m_wb_adr_o,
  output logic [WB_DAT_BITS-1:0] m_wb_dat_o,
  input  logic [WB_DAT_BITS-1:0] m_wb_dat_i,
  output logic                   m_wb_we_o,
  output logic [WB_SEL_BITS-1:0] m_wb_sel_o,
  output logic                   m_wb_stb_o,
  input  logic                   m_wb_ack_i,
  output logic                   timeout_o,
  output logic [15:0]            timeout_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state, state_next;
  logic   capture;
  logic   wd_expire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  assign capture = (state == ST_IDLE) && s_wb_stb_i;

  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (s_wb_stb_i) state_next = ST_REQ;
      ST_REQ:  if (m_wb_ack_i || wd_expire) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobe and acknowledge come straight from flops so neither side sees decode logic.
  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      m_wb_adr_o <= '0;
      m_wb_dat_o <= '0;
      m_wb_we_o  <= 1'b0;
      m_wb_sel_o <= '0;
      m_wb_stb_o <= 1'b0;
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
    end else begin
      m_wb_stb_o <= (state_next == ST_REQ);
      s_wb_ack_o <= (state_next == ST_ACK);
      if (capture) begin
        m_wb_adr_o <= s_wb_adr_i;
        m_wb_dat_o <= s_wb_dat_i;
        m_wb_we_o  <= s_wb_we_i;
        m_wb_sel_o <= s_wb_sel_i;
      end
      if (state == ST_REQ && m_wb_ack_i) begin
        s_wb_dat_o <= m_wb_dat_i;
      end else if (wd_expire) begin
        s_wb_dat_o <= TIMEOUT_DATA[WB_DAT_BITS-1:0];
      end
    end
  end

`ifdef WISHBONE_SLICE_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic [15:0] to_count;
  logic        to_pulse;

  // A real acknowledge in the expiry cycle takes priority over the watchdog.
  assign wd_expire = (state == ST_REQ) && !m_wb_ack_i && (wd_cnt == WD_LAST);

  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      wd_cnt   <= '0;
      to_count <= '0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= wd_expire;
      if (capture) begin
        wd_cnt <= '0;
      end else if (state == ST_REQ && !m_wb_ack_i && !wd_expire) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (wd_expire && to_count != 16'hFFFF) begin
        to_count <= to_count + 16'd1;
      end
    end
  end

  assign timeout_o       = to_pulse;
  assign timeout_count_o = to_count;
`else
  assign wd_expire       = 1'b0;
  assign timeout_o       = 1'b0;
  assign timeout_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_wishbone_slice_timeout.sv
// tb/tb_wishbone_slice_timeout.sv - directed bench for wishbone_slice_timeout (TIMEOUT_CYCLES=8)
// Timeout cases are exercised when WISHBONE_SLICE_TIMEOUT_EN is defined.
module tb_wishbone_slice_timeout;

  logic        clk;
  logic        rst;
  logic [12:0] s_adr;
  logic [63:0] s_dat_w;
  logic [63:0] s_dat_r;
  logic        s_we;
  logic [7:0]  s_sel;
  logic        s_stb;
  logic        s_ack;
  logic [12:0] m_adr;
  logic [63:0] m_dat_w;
  logic [63:0] m_dat_r;
  logic        m_we;
  logic [7:0]  m_sel;
  logic        m_stb;
  logic        m_ack;
  logic        tmo;
  logic [15:0] tmo_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_tc = 16'h0000;

  wishbone_slice_timeout #(
    .WB_ADR_BITS   (13),
    .WB_DAT_BITS   (64),
    .WB_SEL_BITS   (8),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (64'hDEAD_BEEF_DEAD_BEEF)
  ) dut (
    .s_wb_clk_i     (clk),
    .s_wb_rst_i     (rst),
    .s_wb_adr_i     (s_adr),
    .s_wb_dat_i     (s_dat_w),
    .s_wb_dat_o     (s_dat_r),
    .s_wb_we_i      (s_we),
    .s_wb_sel_i     (s_sel),
    .s_wb_stb_i     (s_stb),
    .s_wb_ack_o     (s_ack),
    .m_wb_adr_o     (m_adr),
    .m_wb_dat_o     (m_dat_w),
    .m_wb_dat_i     (m_dat_r),
    .m_wb_we_o      (m_we),
    .m_wb_sel_o     (m_sel),
    .m_wb_stb_o     (m_stb),
    .m_wb_ack_i     (m_ack),
    .timeout_o      (tmo),
    .timeout_count_o(tmo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE at #1 after an edge. k is the REQ cycle in which the slave acks (0 = never).
  task automatic access(input string tag, input logic we, input logic [12:0] adr,
                        input logic [63:0] wdat, input logic [7:0] sel, input int k,
                        input logic [63:0] rdat, input logic [63:0] exp_dat,
                        input int exp_req, input logic exp_to, input logic keep_stb);
    int n;
    int stb_cycles;
    logic done;
    s_stb = 1'b1; s_we = we; s_adr = adr; s_dat_w = wdat; s_sel = sel;
    tick();
    check({tag, "_m_stb_rise"}, m_stb, 1'b1);
    check({tag, "_m_adr"}, m_adr, adr);
    check({tag, "_m_we"}, m_we, we);
    check({tag, "_m_sel"}, m_sel, sel);
    if (we) check({tag, "_m_dat"}, m_dat_w, wdat);
    n = 1; stb_cycles = 0; done = 1'b0;
    while (!done && n <= 100) begin
      if (m_stb) stb_cycles++;
      if (n == k) begin
        m_ack = 1'b1;
        m_dat_r = rdat;
      end
      tick();
      m_ack = 1'b0;
      m_dat_r = 64'h5555_AAAA_5555_AAAA;
      if (s_ack) done = 1'b1;
      else n++;
    end
    check({tag, "_ack_seen"}, done, 1'b1);
    check({tag, "_req_cycles"}, n, exp_req);
    check({tag, "_stb_cycles"}, stb_cycles, exp_req);
    check({tag, "_stb_low_in_ack"}, m_stb, 1'b0);
    if (!we || exp_to) check({tag, "_rdata"}, s_dat_r, exp_dat);
    check({tag, "_timeout_pulse"}, tmo, exp_to);
    tick();
    check({tag, "_ack_single"}, s_ack, 1'b0);
    check({tag, "_timeout_drop"}, tmo, 1'b0);
    if (!keep_stb) s_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_adr = '0; s_dat_w = '0; s_we = 1'b0; s_sel = '0; s_stb = 1'b0;
    m_dat_r = '0; m_ack = 1'b0;
    tick(); tick();
    check("rst_m_stb", m_stb, 1'b0);
    check("rst_s_ack", s_ack, 1'b0);
    check("rst_m_adr", m_adr, 13'h0);
    check("rst_m_dat", m_dat_w, 64'h0);
    check("rst_m_we", m_we, 1'b0);
    check("rst_m_sel", m_sel, 8'h0);
    check("rst_s_dat", s_dat_r, 64'h0);
    check("rst_tmo", tmo, 1'b0);
    check("rst_tmo_cnt", tmo_cnt, 16'h0);
    rst = 1'b0;
    tick();

    access("wr1", 1'b1, 13'h010, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0,
           64'h0, 1, 1'b0, 1'b0);
    tick();
    access("rd4", 1'b0, 13'h020, 64'h0, 8'hFF, 4, 64'hCAFE,
           64'hCAFE, 4, 1'b0, 1'b0);
    tick();

`ifdef WISHBONE_SLICE_TIMEOUT_EN
    access("tmo", 1'b0, 13'h030, 64'h0, 8'h0F, 0, 64'h0,
           64'hDEAD_BEEF_DEAD_BEEF, 8, 1'b1, 1'b0);
    exp_tc = 16'h0001;
    check("tmo_count_1", tmo_cnt, exp_tc);
`else
    access("hang", 1'b0, 13'h030, 64'h0, 8'h0F, 30, 64'h1357_9BDF,
           64'h1357_9BDF, 30, 1'b0, 1'b0);
    check("tmo_count_off", tmo_cnt, exp_tc);
`endif
    tick();
    access("exp_ack", 1'b0, 13'h040, 64'h0, 8'hF0, 8, 64'h0BAD_F00D_1234_5678,
           64'h0BAD_F00D_1234_5678, 8, 1'b0, 1'b0);
    check("exp_ack_count", tmo_cnt, exp_tc);
    tick();

    // Reset in the third REQ cycle must drop the strobe without waiting for an edge.
    s_stb = 1'b1; s_we = 1'b1; s_adr = 13'h055; s_dat_w = 64'h77; s_sel = 8'h01;
    tick(); tick(); tick();
    check("mid_req_stb", m_stb, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_async_stb", m_stb, 1'b0);
    check("rst_async_adr", m_adr, 13'h0);
    s_stb = 1'b0;
    m_ack = 1'b1;
    tick();
    check("rst_no_ack_1", s_ack, 1'b0);
    m_ack = 1'b0;
    tick();
    check("rst_no_ack_2", s_ack, 1'b0);
    check("rst_tmo_cnt_clr", tmo_cnt, 16'h0);
    exp_tc = 16'h0000;
    rst = 1'b0;
    tick();
    check("post_rst_idle_ack", s_ack, 1'b0);
    access("post_rst", 1'b0, 13'h066, 64'h0, 8'hFF, 2, 64'h2468_ACE0,
           64'h2468_ACE0, 2, 1'b0, 1'b0);
    tick();

    // Stray acknowledge while idle must leave every output alone.
    m_ack = 1'b1; m_dat_r = 64'hFFFF_0000_FFFF_0000;
    tick();
    m_ack = 1'b0;
    check("stray_s_ack", s_ack, 1'b0);
    check("stray_m_stb", m_stb, 1'b0);
    check("stray_s_dat", s_dat_r, 64'h2468_ACE0);
    tick();
    check("stray_s_ack_late", s_ack, 1'b0);

    access("b2b_1", 1'b0, 13'h100, 64'h0, 8'hFF, 1, 64'h1111, 64'h1111, 1, 1'b0, 1'b1);
    access("b2b_2", 1'b0, 13'h101, 64'h0, 8'hFF, 1, 64'h2222, 64'h2222, 1, 1'b0, 1'b1);
    access("b2b_3", 1'b0, 13'h102, 64'h0, 8'hFF, 3, 64'h3333, 64'h3333, 3, 1'b0, 1'b0);
    tick(); tick();
    check("b2b_idle_stb", m_stb, 1'b0);
    check("b2b_idle_ack", s_ack, 1'b0);
    check("final_tmo_cnt", tmo_cnt, exp_tc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
